// File: rtl/seq_detect_param.sv
// seq_detect_param
// ----------------
// Serial bit-pattern detector. A Mealy FSM watches a 1-bit stream and
// recognises a WIDTH-bit PATTERN, which is received MSB first. Matching can
// overlap or not, selected at run time. Input bits are consumed only when
// valid_in is high. Matches are counted in a saturating counter.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   clr          synchronous clear of FSM state, counter and saturation flag
//   valid_in     qualifies Data_in; the bit is consumed only when high
//   Data_in      serial data bit
//   overlap      1 = overlapping matches, 0 = restart after each match
//   out          combinational Mealy match pulse
//   match_count  matches since reset/clr, saturating at all-ones
//   count_sat    sticky flag, set once match_count reaches all-ones
module seq_detect_param #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid_in,
  input  logic             Data_in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int SW      = $clog2(WIDTH);
  localparam int NSTATES = 1 << SW;
  localparam int TBL_W   = 2 * NSTATES * SW;

  localparam logic [SW-1:0]    LAST_STATE = SW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // The KMP transition table. The entry for (state s, bit b) is the length of
  // the longest proper pattern prefix that is a suffix of
  // "first s pattern bits followed by b".
  // For the last state with the matching bit, the entry is fail(WIDTH). That
  // is the overlap restart point. Encodings above WIDTH-1 are unreachable and
  // map to 0.
  function automatic logic [TBL_W-1:0] build_next_table();
    logic [TBL_W-1:0] tbl;
    int               best;
    int               j;
    logic             ok;
    logic             sb;
    tbl = '0;
    for (int s = 0; s < WIDTH; s++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int k = WIDTH - 1; k > 0; k--) begin
          if (best == 0 && k <= s + 1) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
              j  = s + 1 - k + i;
              sb = (j == s) ? b[0] : PATTERN[WIDTH-1-j];
              if (sb != PATTERN[WIDTH-1-i]) ok = 1'b0;
            end
            if (ok) best = k;
          end
        end
        tbl[(2*s+b)*SW +: SW] = SW'(best);
      end
    end
    return tbl;
  endfunction

  // Reorders the pattern so that the expected bit in state s is bit s.
  // The vector is padded to the full state-encoding range.
  function automatic logic [NSTATES-1:0] build_expected();
    logic [NSTATES-1:0] e;
    e = '0;
    for (int s = 0; s < WIDTH; s++) e[s] = PATTERN[WIDTH-1-s];
    return e;
  endfunction

  localparam logic [TBL_W-1:0]   NEXT_TBL = build_next_table();
  localparam logic [NSTATES-1:0] EXPECTED = build_expected();

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic [SW:0]   tbl_idx;
  logic [SW-1:0] table_next;
  logic          bit_ok;
  logic          match;

  // Next-state and Mealy output.
  // A match exits through the table's fail(WIDTH) entry in overlapping mode.
  // In non-overlapping mode it exits to state 0.
  always_comb begin
    tbl_idx    = {state, Data_in};
    table_next = NEXT_TBL[int'(tbl_idx)*SW +: SW];
    bit_ok     = (Data_in == EXPECTED[state]);
    match      = rst & valid_in & (state == LAST_STATE) & bit_ok;
    next_state = state;
    if (valid_in) begin
      next_state = table_next;
      if (match && !overlap) next_state = '0;
    end
    out = match;
  end

  // State register. clr wins over any transition, including a match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
    end else if (clr) begin
      state <= '0;
    end else begin
      state <= next_state;
    end
  end

  // Saturating match counter with a sticky flag.
  // clr suppresses the increment of a simultaneous match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clr) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (match && match_count != CNT_MAX) begin
      match_count <= match_count + 1'b1;
      if (match_count == CNT_MAX - 1'b1) count_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param
// -------------------
// Three detector instances share one stimulus stream:
//   a: defaults (1011, 8-bit counter)
//   b: 1011 with a 2-bit counter
//   c: 5'b11011 with an 8-bit counter
// Each instance is compared against a sliding-window model. A match occurs
// when the last WIDTH consumed bits equal the pattern. The window is emptied
// after a match in non-overlapping mode and kept in overlapping mode.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic valid_in = 1'b0;
  logic data_in = 1'b0;
  logic overlap = 1'b0;

  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;
  logic       sat_a, sat_b, sat_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_param dut_a (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .Data_in(data_in),
    .overlap(overlap), .out(out_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .Data_in(data_in),
    .overlap(overlap), .out(out_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  seq_detect_param #(.WIDTH(5), .PATTERN(5'b11011), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .Data_in(data_in),
    .overlap(overlap), .out(out_c), .match_count(cnt_c), .count_sat(sat_c)
  );

  // Reference model state, one entry per instance.
  int          m_w[3]   = '{4, 4, 5};
  logic [63:0] m_pat[3] = '{64'hB, 64'hB, 64'h1B};
  int          m_max[3] = '{255, 3, 255};
  logic [63:0] m_hist[3];
  logic [63:0] m_next[3];
  int          m_len[3];
  int          m_cnt[3];
  int          m_sat[3];
  int          m_exp[3];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = '0;
      m_len[i]  = 0;
      m_cnt[i]  = 0;
      m_sat[i]  = 0;
    end
  endtask

  // Drives one cycle on the falling edge and checks out mid-cycle.
  // After the rising edge, it updates the model and checks the counters.
  task automatic applyStimulus(input logic v, input logic d, input logic ov,
                               input logic c, input logic r);
    logic [63:0] mask;
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    overlap  = ov;
    clr      = c;
    rst      = r;
    if (!r) modelReset();
    for (int i = 0; i < 3; i++) begin
      m_next[i] = {m_hist[i][62:0], d};
      mask      = (64'd1 << m_w[i]) - 64'd1;
      m_exp[i]  = (r && v && (m_len[i] + 1 >= m_w[i]) &&
                   ((m_next[i] & mask) == m_pat[i])) ? 1 : 0;
    end
    #1;
    checkOutput("out_a", int'(out_a), m_exp[0]);
    checkOutput("out_b", int'(out_b), m_exp[1]);
    checkOutput("out_c", int'(out_c), m_exp[2]);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        if (c) begin
          m_hist[i] = '0;
          m_len[i]  = 0;
          m_cnt[i]  = 0;
          m_sat[i]  = 0;
        end else if (v) begin
          if (m_exp[i] != 0) begin
            if (m_cnt[i] < m_max[i]) m_cnt[i]++;
            if (m_cnt[i] == m_max[i]) m_sat[i] = 1;
          end
          if (m_exp[i] != 0 && !ov) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
          end else begin
            m_hist[i] = m_next[i];
            m_len[i]  = (m_len[i] < 63) ? m_len[i] + 1 : 63;
          end
        end
      end
    end
    #1;
    checkOutput("count_a", int'(cnt_a), m_cnt[0]);
    checkOutput("count_b", int'(cnt_b), m_cnt[1]);
    checkOutput("count_c", int'(cnt_c), m_cnt[2]);
    checkOutput("sat_a", int'(sat_a), m_sat[0]);
    checkOutput("sat_b", int'(sat_b), m_sat[1]);
    checkOutput("sat_c", int'(sat_c), m_sat[2]);
  endtask

  logic [15:0] stream_a;
  logic [15:0] stream_b;
  logic [7:0]  stream_c;

  initial begin
    modelReset();
    stream_a = 16'b1011011011101101;
    stream_b = 16'b1011011011011011;
    stream_c = 8'b11011011;

    // Reset state, including out being forced low under reset.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Non-overlapping stream: matches on bits 3, 9 and 13.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 15; i >= 0; i--) applyStimulus(1'b1, stream_a[i], 1'b0, 1'b0, 1'b1);
    checkOutput("plan_nonovl_count", int'(cnt_a), 3);

    // Overlapping stream: matches on bits 3, 6, 9 and 13.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 15; i >= 0; i--) applyStimulus(1'b1, stream_a[i], 1'b1, 1'b0, 1'b1);
    checkOutput("plan_ovl_count", int'(cnt_a), 4);

    // Gaps in valid_in between the bits of 1,0,1,1.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, stream_a[12+i], 1'b0, 1'b0, 1'b1);
      if (i != 0) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("plan_gap_count", int'(cnt_a), 1);

    // Reset mid-pattern discards the partial match.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("plan_rst_no_match", int'(cnt_a), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("plan_rst_then_match", int'(cnt_a), 1);

    // Counter saturation on the 2-bit instance, then clr.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 15; i >= 0; i--) applyStimulus(1'b1, stream_b[i], 1'b1, 1'b0, 1'b1);
    checkOutput("plan_sat_count", int'(cnt_b), 3);
    checkOutput("plan_sat_flag", int'(sat_b), 1);
    checkOutput("plan_unsat_count", int'(cnt_a), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("plan_clr_count", int'(cnt_b), 0);
    checkOutput("plan_clr_flag", int'(sat_b), 0);

    // clr coinciding with a match: out pulses but nothing is counted.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("plan_clr_match_count", int'(cnt_b), 0);

    // Five-bit pattern 11011, with overlap and then without.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, stream_c[i], 1'b1, 1'b0, 1'b1);
    checkOutput("plan_w5_ovl_count", int'(cnt_c), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, stream_c[i], 1'b0, 1'b0, 1'b1);
    checkOutput("plan_w5_nonovl_count", int'(cnt_c), 1);

    // Randomised traffic with occasional clr and reset.
    for (int n = 0; n < 800; n++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 31) == 0),
                    logic'($urandom_range(0, 63) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
